// File: rtl/instr_mem_pipe_pkg.sv
// Shared defines for the instruction memory pipe.
// Opcodes, halt word and control FSM encoding.
package instr_mem_pipe_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_MPY  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h4;
  localparam logic [3:0] OP_BR   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hf;

  localparam logic [DEF_WIDTH-1:0] HALT_WORD =
    {OP_HALT, 28'h0};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/instr_mem_pipe_imem_array.sv
// Instruction storage: one write port, one
// registered read port, contents never reset.
module imem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // only the output register clears; the array keeps its program
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_pipe.sv
// Fetch pipe: valid/ready instruction memory
// with program-load FSM and flush.
module instr_mem_pipe
  import instr_mem_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  inst,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data
);

  localparam logic [WIDTH-1:0] HALT =
    WIDTH'(HALT_WORD);

  state_t state_q, state_d;
  logic fire, take, oob;
  logic fault_q;
  logic [WIDTH-1:0] rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (ld_en) state_d = LOAD;
      LOAD:    if (!ld_en) state_d = DRAIN;
      DRAIN:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // reads never overlap a write: ld_en blocks acceptance
  assign req_ready = (state_q == RUN) && !ld_en
                  && (!rsp_valid || rsp_ready);
  assign fire = req_valid && req_ready;
  assign take = fire && !flush;
  assign oob  = pc >= 32'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      fault_q   <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (fire) begin
      rsp_valid <= 1'b1;
      fault_q   <= oob;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  imem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .INIT  (HALT)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (ld_en),
    .waddr(ld_addr),
    .wdata(ld_data),
    .re   (take),
    .raddr(pc[ADDR_W-1:0]),
    .rdata(rdata)
  );

  assign inst      = fault_q ? HALT : rdata;
  assign rsp_fault = fault_q;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: directed scenarios
// plus random traffic against a reference model.
module tb_instr_mem_pipe;
  import instr_mem_pipe_pkg::*;

  localparam logic [31:0] HALT = 32'hf000_0000;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] inst;
  logic        rsp_fault;
  logic        flush = 1'b0;
  logic        ld_en = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  instr_mem_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .pc       (pc),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .inst     (inst),
    .rsp_fault(rsp_fault),
    .flush    (flush),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  always #5 clk = ~clk;

  // reference: memory image, expected response, load blackout
  logic [31:0] mmem [DEPTH];
  logic        mv, mf;
  logic [31:0] minst;
  int          quiet;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rv,
                      input logic [31:0] p,
                      input logic rr,
                      input logic fl,
                      input logic le,
                      input logic [5:0] la,
                      input logic [31:0] ld);
    logic rdy;
    @(negedge clk);
    req_valid = rv; pc = p; rsp_ready = rr;
    flush = fl; ld_en = le; ld_addr = la;
    ld_data = ld;
    #1;
    rdy = (quiet == 0) && !le && (!mv || rr);
    chk("req_ready", 64'(req_ready), 64'(rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(mv));
    if (mv) begin
      chk("inst", 64'(inst), 64'(minst));
      chk("rsp_fault", 64'(rsp_fault), 64'(mf));
    end
    if (fl) mv = 1'b0;
    else if (rv && rdy) begin
      mv = 1'b1;
      mf = p >= DEPTH;
      minst = mf ? HALT : mmem[p[5:0]];
    end else if (rr) mv = 1'b0;
    // writes are followed by two idle cycles (LOAD, DRAIN)
    if (le) begin
      mmem[la] = ld;
      quiet = 2;
    end else if (quiet > 0) quiet--;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 0; flush = 0;
    ld_en = 0; rsp_ready = 0;
    #1;
    chk("rst_valid", 64'(rsp_valid), 64'(0));
    chk("rst_inst", 64'(inst), 64'(0));
    chk("rst_fault", 64'(rsp_fault), 64'(0));
    mv = 0; mf = 0; minst = '0; quiet = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(1));
  endtask

  logic [31:0] prog [8];
  int burst;
  logic rv, rr, fl, le;
  logic [31:0] p;

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = HALT;
    mv = 0; mf = 0; minst = '0; quiet = 0;
    prog[0] = {OP_MOV, 28'h0010_005};
    prog[1] = {OP_MOV, 28'h0020_007};
    prog[2] = {OP_MPY, 28'h0312_000};
    prog[3] = {OP_ADD, 28'h0433_001};
    prog[4] = {OP_CMP, 28'h0004_023};
    prog[5] = {OP_BR,  28'h0000_002};
    prog[6] = {OP_ADD, 28'h0541_000};
    prog[7] = HALT;
    do_reset();

    // program load then sequential fetch
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, 0, 1, 6'(i), prog[i]);
    idle(2);
    for (int i = 0; i < 8; i++)
      step(1, 32'(i), 1, 0, 0, 0, 0);
    idle(1);

    // out of range, no aliasing onto entry 0
    step(1, 64, 1, 0, 0, 0, 0);
    step(1, 32'h8000_0001, 1, 0, 0, 0, 0);
    idle(1);

    // backpressure holds response
    step(1, 2, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 3, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(1);

    // load while idle, fetch at first ready
    step(0, 0, 1, 0, 1, 5, 32'hdead_beef);
    for (int i = 0; i < 3; i++)
      step(1, 5, 1, 0, 0, 0, 0);
    idle(1);

    // flush with concurrent fire
    step(1, 4, 0, 0, 0, 0, 0);
    step(1, 3, 1, 1, 0, 0, 0);
    idle(2);

    // reset in the middle of a load
    step(0, 0, 1, 0, 1, 1, 32'h1234_5678);
    do_reset();
    step(1, 1, 1, 0, 0, 0, 0);
    idle(1);

    // random traffic
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      le = 0;
      if (burst > 0) begin
        le = 1;
        burst--;
      end else if (quiet == 0 && $urandom_range(0, 29) == 0) begin
        le = 1;
        burst = $urandom_range(0, 3);
      end
      rv = $urandom_range(0, 9) < 7;
      rr = $urandom_range(0, 9) < 7;
      fl = $urandom_range(0, 9) == 0;
      case ($urandom_range(0, 9))
        0: p = 32'($urandom_range(64, 127));
        1: p = $urandom;
        default: p = 32'($urandom_range(0, 63));
      endcase
      step(rv, p, rr, fl, le,
           6'($urandom_range(0, 63)), $urandom);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
